// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x3 keypad scanner: FSM states,
// column drive patterns, special key codes and the (row,col) key map.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  localparam logic [2:0] COL0_DRIVE = 3'b110;
  localparam logic [2:0] COL1_DRIVE = 3'b101;
  localparam logic [2:0] COL2_DRIVE = 3'b011;
  localparam logic [3:0] ROWS_IDLE  = 4'b1111;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  function automatic logic [2:0] col_drive(input logic [1:0] col);
    case (col)
      2'd1:    col_drive = COL1_DRIVE;
      2'd2:    col_drive = COL2_DRIVE;
      default: col_drive = COL0_DRIVE;
    endcase
  endfunction

  // Rows are active low; the lowest-numbered pressed row wins.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] r);
    if (!r[0])      lowest_low_row = 2'd0;
    else if (!r[1]) lowest_low_row = 2'd1;
    else if (!r[2]) lowest_low_row = 2'd2;
    else            lowest_low_row = 2'd3;
  endfunction

  function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'b00_00: key_decode = KEY_HASH;
      4'b00_01: key_decode = 4'd0;
      4'b00_10: key_decode = KEY_STAR;
      4'b01_00: key_decode = 4'd9;
      4'b01_01: key_decode = 4'd8;
      4'b01_10: key_decode = 4'd7;
      4'b10_00: key_decode = 4'd6;
      4'b10_01: key_decode = 4'd5;
      4'b10_10: key_decode = 4'd4;
      4'b11_00: key_decode = 4'd3;
      4'b11_01: key_decode = 4'd2;
      4'b11_10: key_decode = 4'd1;
      default:  key_decode = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer bank for asynchronous inputs; resets to all-ones
// so an idle (active-low) bus looks idle straight out of reset.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        meta_reg[gi] <= 1'b1;
        sync_reg[gi] <= 1'b1;
      end else begin
        meta_reg[gi] <= d[gi];
        sync_reg[gi] <= meta_reg[gi];
      end
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: walks the columns, debounces a press, reports
// it once, then waits for a debounced release before scanning again.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] columns,
  input  logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

  logic [3:0] srows;

  state_t           state_reg, state_next;
  logic [1:0]       col_reg, col_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [DEB_W-1:0] deb_reg, deb_next;
  logic [3:0]       pattern_reg, pattern_next;
  logic [1:0]       row_reg, row_next;
  logic [3:0]       key_code_reg, key_code_next;
  logic             key_valid_reg, key_valid_next;
  logic             key_held_reg, key_held_next;
  logic [1:0]       col_after;

  keypad_sync #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (srows)
  );

  assign col_after = (col_reg == 2'd2) ? 2'd0 : col_reg + 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_SCAN;
      col_reg       <= 2'd0;
      div_reg       <= '0;
      deb_reg       <= '0;
      pattern_reg   <= ROWS_IDLE;
      row_reg       <= 2'd0;
      key_code_reg  <= 4'd0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      div_reg       <= div_next;
      deb_reg       <= deb_next;
      pattern_reg   <= pattern_next;
      row_reg       <= row_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    div_next       = div_reg;
    deb_next       = deb_reg;
    pattern_next   = pattern_reg;
    row_next       = row_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;

    case (state_reg)
      ST_SCAN: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (srows != ROWS_IDLE) begin
            // Column stays frozen while the candidate is debounced.
            pattern_next = srows;
            row_next     = lowest_low_row(srows);
            deb_next     = '0;
            state_next   = ST_DEBOUNCE;
          end else begin
            col_next = col_after;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (srows == pattern_reg) begin
          if (deb_reg == DEB_LAST) begin
            key_code_next  = key_decode(row_reg, col_reg);
            key_valid_next = 1'b1;
            key_held_next  = 1'b1;
            deb_next       = '0;
            state_next     = ST_HELD;
          end else begin
            deb_next = deb_reg + 1'b1;
          end
        end else begin
          deb_next   = '0;
          div_next   = '0;
          col_next   = col_after;
          state_next = ST_SCAN;
        end
      end

      ST_HELD: begin
        if (srows == ROWS_IDLE) begin
          deb_next   = '0;
          state_next = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (srows == ROWS_IDLE) begin
          if (deb_reg == DEB_LAST) begin
            key_held_next = 1'b0;
            deb_next      = '0;
            div_next      = '0;
            col_next      = col_after;
            state_next    = ST_SCAN;
          end else begin
            deb_next = deb_reg + 1'b1;
          end
        end else begin
          deb_next   = '0;
          state_next = ST_HELD;
        end
      end

      default: begin
        state_next = ST_SCAN;
      end
    endcase
  end

  assign columns   = col_drive(col_reg);
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed plus randomized bench: a model keypad shorts rows to the driven
// column; accepted keys are compared with the key the bench pressed.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] columns;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [11:0] pressed = '0;
  int          vectors = 0;
  int          miscompares = 0;
  int          valid_cnt = 0;
  logic [3:0]  last_code = 4'd0;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clk       (clk),
    .reset     (reset),
    .columns   (columns),
    .rows      (rows),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad layout: 1..9 fill rows 3..1 right-to-left, bottom row is # 0 *.
  function automatic int row_of(input int k);
    if (k >= 1 && k <= 9) return 3 - (k - 1) / 3;
    return 0;
  endfunction

  function automatic int col_of(input int k);
    if (k >= 1 && k <= 9) return 2 - (k - 1) % 3;
    if (k == 0) return 1;
    if (k == 10) return 2;
    return 0;
  endfunction

  always_comb begin
    rows = 4'b1111;
    for (int k = 0; k < 12; k++)
      if (pressed[k] && !columns[col_of(k)]) rows[row_of(k)] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (key_valid) begin
      valid_cnt = valid_cnt + 1;
      last_code = key_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int base;
    int run;
    int hold_min;
    int k;
    int hold;
    logic [2:0] seen;
    bit found;

    // Reset state
    tick(3);
    check("reset_columns", 32'(columns), 32'(3'b110));
    check("reset_key_code", 32'(key_code), 0);
    check("reset_outputs", 32'({key_valid, key_held}), 0);
    reset = 1'b0;
    tick(5);

    // Key 5 held 100 clocks: one pulse, held until debounced release
    base = valid_cnt;
    pressed[5] = 1'b1;
    tick(100);
    check("k5_valid_count", 32'(valid_cnt - base), 1);
    check("k5_code", 32'(last_code), 5);
    check("k5_held", 32'(key_held), 1);
    pressed[5] = 1'b0;
    tick(8);
    check("k5_held_8_after", 32'(key_held), 1);
    tick(6);
    check("k5_released", 32'(key_held), 0);
    check("k5_code_kept", 32'(key_code), 5);
    tick(20);

    // Key 1 bouncing then released: never accepted, scanning goes on
    base = valid_cnt;
    for (int i = 0; i < 12; i++) begin
      pressed[1] = 1'b1;
      tick(5);
      pressed[1] = 1'b0;
      tick(1);
    end
    tick(20);
    check("bounce_no_valid", 32'(valid_cnt - base), 0);
    seen = 3'b000;
    for (int i = 0; i < 3 * SCAN_DIV + 2; i++) begin
      tick(1);
      if (columns == 3'b110) seen[0] = 1'b1;
      if (columns == 3'b101) seen[1] = 1'b1;
      if (columns == 3'b011) seen[2] = 1'b1;
    end
    check("bounce_scan_continues", 32'(seen), 32'(3'b111));

    // Rows 1 and 3 low in column 0: row 1 (key 9) wins
    base = valid_cnt;
    pressed[9] = 1'b1;
    pressed[3] = 1'b1;
    tick(60);
    check("multi_row_count", 32'(valid_cnt - base), 1);
    check("multi_row_code", 32'(last_code), 9);
    pressed[9] = 1'b0;
    pressed[3] = 1'b0;
    tick(30);

    // # held, then * added: only # reported; * alone afterwards
    base = valid_cnt;
    pressed[11] = 1'b1;
    tick(40);
    pressed[10] = 1'b1;
    tick(60);
    check("hash_star_count", 32'(valid_cnt - base), 1);
    check("hash_code", 32'(last_code), 11);
    pressed[11] = 1'b0;
    pressed[10] = 1'b0;
    tick(30);
    base = valid_cnt;
    pressed[10] = 1'b1;
    tick(60);
    check("star_count", 32'(valid_cnt - base), 1);
    check("star_code", 32'(last_code), 10);
    pressed[10] = 1'b0;
    tick(30);

    // Reset in the middle of debouncing key 7
    base = valid_cnt;
    pressed[7] = 1'b1;
    run = 0;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick(1);
      if (columns == 3'b011) run++;
      else run = 0;
      if (run == SCAN_DIV + 1) found = 1'b1;
    end
    check("k7_debounce_reached", 32'(found), 1);
    tick(2);
    reset = 1'b1;
    tick(1);
    check("k7_in_reset", 32'({columns, key_code, key_valid, key_held}), 32'({3'b110, 6'd0}));
    pressed[7] = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    check("k7_after_reset", 32'({columns, key_code, key_valid, key_held}), 32'({3'b110, 6'd0}));
    tick(30);
    check("k7_no_valid", 32'(valid_cnt - base), 0);

    // Release glitch on key 4: held stays high, no second pulse
    base = valid_cnt;
    pressed[4] = 1'b1;
    tick(60);
    pressed[4] = 1'b0;
    hold_min = 1;
    tick(3);
    if (!key_held) hold_min = 0;
    pressed[4] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!key_held) hold_min = 0;
    end
    check("glitch_held", 32'(hold_min), 1);
    pressed[4] = 1'b0;
    tick(25);
    check("glitch_count", 32'(valid_cnt - base), 1);
    check("glitch_code", 32'(last_code), 4);
    check("glitch_released", 32'(key_held), 0);

    // Random single presses
    for (int i = 0; i < 8; i++) begin
      k = int'($urandom_range(0, 11));
      hold = int'($urandom_range(40, 120));
      base = valid_cnt;
      pressed[k] = 1'b1;
      tick(hold);
      check($sformatf("rand%0d_held", i), 32'(key_held), 1);
      pressed[k] = 1'b0;
      tick(30);
      check($sformatf("rand%0d_count", i), 32'(valid_cnt - base), 1);
      check($sformatf("rand%0d_code", i), 32'(last_code), 32'(k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16, meaning clocks each column is driven per scan step (legal range 4 or more).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 1000, meaning consecutive stable clocks required to accept a press or a release.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port: columns  output  3  column drive, active low, exactly one bit low.
REQ-007 SHALL have port: rows  input  4  row sense, active low, idle 4'b1111, asynchronous to clk.
REQ-008 SHALL have port: key_code  output  4  code of last accepted key, 0-9 digits, 10 = * (alarm), 11 = # (time).
REQ-009 SHALL have port: key_valid  output  1  one-clock pulse when a new key is accepted.
REQ-010 SHALL have port: key_held  output  1  high from acceptance until the release is accepted.

Function
REQ-011 SHALL pass rows through a 2-flop synchronizer; all decisions use synchronized rows (srows).
REQ-012 SHALL decode (row,col) as: (0,1)=0, (3,2)=1, (3,1)=2, (3,0)=3, (2,2)=4, (2,1)=5, (2,0)=6, (1,2)=7, (1,1)=8, (1,0)=9, (0,2)=10, (0,0)=11; col n is active when columns[n]=0.
REQ-013 SHALL implement states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-014 SCAN: SHALL drive columns 3'b110 -> 3'b101 -> 3'b011 -> 3'b110, each for SCAN_DIV clocks; SHALL sample srows on the last dwell clock.
REQ-015 SCAN sample with srows != 4'b1111: SHALL latch column and lowest-index low row, freeze columns, and enter DEBOUNCE; otherwise advance to the next column.
REQ-016 DEBOUNCE: SHALL count clocks where srows equals the latched pattern; any mismatch SHALL return to SCAN with the next column and discard the candidate.
REQ-017 On the DEBOUNCE_CNT-th matching clock: SHALL update key_code, pulse key_valid for exactly one clock, set key_held, and enter HELD.
REQ-018 HELD: SHALL keep columns frozen; SHALL enter RELEASE when srows = 4'b1111.
REQ-019 RELEASE: SHALL count consecutive clocks of srows = 4'b1111; any low row SHALL return to HELD with the counter cleared.
REQ-020 On the DEBOUNCE_CNT-th idle clock: SHALL clear key_held and resume SCAN at the next column.
REQ-021 Holding a key indefinitely SHALL produce exactly one key_valid.
REQ-022 Multiple low rows in one column SHALL resolve to the lowest row index; keys in other columns are ignored until the release is accepted.
REQ-023 key_code SHALL hold its value between acceptances.
REQ-024 Counters SHALL be sized by $clog2 of their parameter and SHALL saturate rather than wrap.

Reset
REQ-025 While reset is high: state = SCAN, columns = 3'b110, key_code = 0, key_valid = 0, key_held = 0, and counters and synchronizer = idle (4'b1111).
REQ-026 Reset asserted mid-DEBOUNCE, HELD or RELEASE SHALL abort without a key_valid pulse; after deassertion, scanning restarts at column 0.

Structure
REQ-027 A shared package keypad_pkg SHALL hold the state enum, column drive constants, and KEY_STAR=10 and KEY_HASH=11.
REQ-028 The synchronizer SHALL be sub-module keypad_sync (parameterized width, 2 flops, async reset to all-ones).

Verification
REQ-029 SCAN_DIV=4, DEBOUNCE_CNT=8, key 5 (row2 low while col1 driven) held 100 clocks -> one key_valid with key_code=5; key_held high until 8 clocks after release.
REQ-030 Key 1 bouncing (low 5 clocks, high 1, repeated) and then released -> no key_valid, and scanning continues.
REQ-031 Rows 1 and 3 low together in col0 -> key_code=9.
REQ-032 Key 11 pressed, then key 10 pressed while 11 is still held -> only code 11 is reported; after both are released and key 10 is pressed alone -> code 10.
REQ-033 Reset pulse during DEBOUNCE of key 7 -> no key_valid, columns=3'b110 in the clock after reset, and all outputs are 0.
REQ-034 Release glitch (rows return to 1111 for 3 clocks, then low again) during RELEASE -> key_held stays high and there is no second key_valid.
